uart_ub_readback_tx: RTL

Transmit-side engine of the host UART protocol. It serves the PC-bound direction: Unified Buffer readback (command 0x04), status reporting (command 0x06) and single-byte ACK/NACK codes. It accepts one request at a time from the command FSM, reads 256-bit UB rows and serializes them as bytes. Its output feeds the byte-wide `uart_tx` input handshake.

---
 rtl/uart_ub_readback_tx_if.sv | 29 ++
 rtl/uart_ub_readback_tx.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/uart_ub_readback_tx_if.sv
// Request, UB-read and byte-transmit channels of the UART readback engine.
// The slave modport is the engine's view; master is the command FSM / UB / transmitter side.
interface uart_ub_readback_tx_if #(
  parameter int UB_ADDR_W = 8,
  parameter int LEN_W     = 16
);
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_kind;
  logic [UB_ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]     req_len;
  logic [7:0]           req_code;
  logic                 ub_rd_en;
  logic [UB_ADDR_W-1:0] ub_rd_addr;
  logic [255:0]         ub_rd_data;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport slave (
    input  req_valid, req_kind, req_addr, req_len, req_code, ub_rd_data, tx_ready,
    output req_ready, ub_rd_en, ub_rd_addr, tx_data, tx_valid
  );

  modport master (
    output req_valid, req_kind, req_addr, req_len, req_code, ub_rd_data, tx_ready,
    input  req_ready, ub_rd_en, ub_rd_addr, tx_data, tx_valid
  );
endinterface

// File: rtl/uart_ub_readback_tx.sv
// PC-bound UART engine: serializes Unified Buffer rows, status bytes and ACK codes
// onto the byte-wide transmitter handshake, one request at a time.
module uart_ub_readback_tx #(
  parameter int UB_ADDR_W = 8,
  parameter int LEN_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  uart_ub_readback_tx_if.slave bus,
  input  logic               sys_busy,
  input  logic               sys_done,
  input  logic               vpu_busy,
  input  logic               vpu_done,
  input  logic               ub_busy,
  input  logic               ub_done,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1'b1);

  function automatic logic [7:0] pack_status(
    input logic sb, input logic sd, input logic vb,
    input logic vd, input logic ubb, input logic ubd
  );
    return {2'b00, ubd, ubb, vd, vb, sd, sb};
  endfunction

  state_t               state_r, state_s;
  logic [UB_ADDR_W-1:0] ptr_r;
  logic [LEN_W-1:0]     rem_r;
  logic [4:0]           idx_r;
  logic [255:0]         row_r;
  logic [7:0]           tx_data_r;
  logic                 tx_valid_r, ub_rd_en_r, busy_r, done_r, req_ready_r;

  logic                 accept_s, xfer_s, last_byte_s;
  logic [4:0]           idx_inc_s;

  // Next-state decode and handshake qualifiers
  always_comb begin
    state_s     = state_r;
    accept_s    = (state_r == S_IDLE) && bus.req_valid;
    xfer_s      = (state_r == S_SEND) && tx_valid_r && bus.tx_ready;
    last_byte_s = (rem_r == LEN_ONE);
    idx_inc_s   = idx_r + 5'd1;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          case (bus.req_kind)
            2'd0:    state_s = (bus.req_len == '0) ? S_FIN : S_RD;
            2'd1:    state_s = S_SEND;
            2'd2:    state_s = S_SEND;
            default: state_s = S_FIN;
          endcase
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RD:   state_s = S_WAIT;
      S_WAIT: state_s = S_SEND;
      S_SEND: begin
        if (!xfer_s) begin
          state_s = S_SEND;
        end else if (last_byte_s) begin
          state_s = S_FIN;
        end else if (idx_r == 5'd31) begin
          state_s = S_RD;
        end else begin
          state_s = S_SEND;
        end
      end
      S_FIN:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Row pointer, byte counters, row buffer and the byte presented to the transmitter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r     <= '0;
      rem_r     <= '0;
      idx_r     <= 5'd0;
      row_r     <= '0;
      tx_data_r <= 8'h00;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            ptr_r     <= bus.req_addr;
            // Single-byte kinds reuse the counter so SEND ends after one transfer
            rem_r     <= (bus.req_kind == 2'd0) ? bus.req_len : LEN_ONE;
            tx_data_r <= (bus.req_kind == 2'd1)
                         ? pack_status(sys_busy, sys_done, vpu_busy, vpu_done, ub_busy, ub_done)
                         : bus.req_code;
          end
        end
        S_RD: idx_r <= 5'd0;
        S_WAIT: begin
          row_r     <= bus.ub_rd_data;
          tx_data_r <= bus.ub_rd_data[7:0];
        end
        S_SEND: begin
          if (xfer_s) begin
            rem_r <= rem_r - LEN_ONE;
            idx_r <= idx_inc_s;
            if (!last_byte_s) begin
              tx_data_r <= row_r[{idx_inc_s, 3'b000} +: 8];
              if (idx_r == 5'd31) begin
                ptr_r <= ptr_r + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Registered control outputs, decoded from the upcoming state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ub_rd_en_r  <= 1'b0;
      tx_valid_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      req_ready_r <= 1'b1;
    end else begin
      ub_rd_en_r  <= (state_s == S_RD);
      tx_valid_r  <= (state_s == S_SEND);
      busy_r      <= (state_s != S_IDLE);
      done_r      <= (state_s == S_FIN);
      req_ready_r <= (state_s == S_IDLE);
    end
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.ub_rd_en   = ub_rd_en_r;
  assign bus.ub_rd_addr = ptr_r;
  assign bus.tx_data    = tx_data_r;
  assign bus.tx_valid   = tx_valid_r;
  assign busy           = busy_r;
  assign done           = done_r;

endmodule
